// File: rtl/x3q16_pkg.sv
// Shared constants for the x3q16 ALU: data width, shift-amount width and
// the 3-bit operation encodings.
package x3q16_pkg;

  localparam int X3Q16_W  = 16;
  localparam int SHAMT_W  = 4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

endpackage

// File: rtl/x3q16_alu_core.sv
// Combinational ALU datapath: operation result plus equal / a-greater-than-b
// compare flags. Arithmetic wraps modulo 2^WIDTH; shifts use only the low
// SHAMT_W bits of b.
module x3q16_alu_core
  import x3q16_pkg::*;
#(
  parameter int WIDTH = X3Q16_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] next_result,
  output logic             next_eq,
  output logic             next_gt
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  // Operation select; carry/borrow fall off the top of the WIDTH-bit result.
  always_comb begin
    next_result = '0;
    case (mode)
      ALU_ADD: next_result = a + b;
      ALU_SUB: next_result = a - b;
      ALU_AND: next_result = a & b;
      ALU_OR:  next_result = a | b;
      ALU_XOR: next_result = a ^ b;
      ALU_NOT: next_result = ~a;
      ALU_SHL: next_result = a << shamt;
      ALU_SHR: next_result = a >> shamt;
      default: next_result = '0;
    endcase
  end

  // Compare flags are independent of mode; unsigned, mutually exclusive.
  always_comb begin
    next_eq = (a == b);
    next_gt = (a > b);
  end

endmodule

// File: rtl/x3q16_alu.sv
// x3q16 execute-stage ALU: combinational core followed by one registered
// output stage. No handshake: one operation is accepted every clock, and the
// outputs show the operands sampled at the most recent rising edge.
module x3q16_alu
  import x3q16_pkg::*;
#(
  parameter int WIDTH = X3Q16_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             equal_flag,
  output logic             greater_a_flag
);

  logic [WIDTH-1:0] next_result;
  logic             next_eq;
  logic             next_gt;

  x3q16_alu_core #(.WIDTH(WIDTH)) u_core (
    .a           (a),
    .b           (b),
    .mode        (mode),
    .next_result (next_result),
    .next_eq     (next_eq),
    .next_gt     (next_gt)
  );

  // Output register; reset (active low) clears it immediately and drops
  // whatever operation was in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result         <= '0;
      equal_flag     <= 1'b0;
      greater_a_flag <= 1'b0;
    end else begin
      result         <= next_result;
      equal_flag     <= next_eq;
      greater_a_flag <= next_gt;
    end
  end

endmodule

// File: tb/tb_x3q16_alu.sv
// Directed bench for x3q16_alu: reset behaviour, arithmetic wrap, logic ops,
// shift boundaries, back-to-back pipelined ops and an asynchronous mid-stream
// reset. Expected values are hand-computed constants.
module tb_x3q16_alu;

  logic        clk;
  logic        reset;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  mode;
  logic [15:0] result;
  logic        equal_flag;
  logic        greater_a_flag;

  int total;
  int bad;

  // Scoreboard entries: {result, equal_flag, greater_a_flag}.
  logic [17:0] exp_q[$];

  x3q16_alu dut (
    .clk            (clk),
    .reset          (reset),
    .a              (a),
    .b              (b),
    .mode           (mode),
    .result         (result),
    .equal_flag     (equal_flag),
    .greater_a_flag (greater_a_flag)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one op, clock it in, and check all three outputs just after the edge.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [2:0] tm, input logic [15:0] er,
                        input logic ee, input logic eg);
    a = ta; b = tb_v; mode = tm;
    @(posedge clk); #1;
    check({tag, ".result"}, {16'h0, result}, {16'h0, er});
    check({tag, ".eq"},     {31'h0, equal_flag}, {31'h0, ee});
    check({tag, ".gt"},     {31'h0, greater_a_flag}, {31'h0, eg});
  endtask

  logic [15:0] pa [8];
  logic [15:0] pb [8];
  logic [2:0]  pm [8];
  logic [17:0] pe [8];

  initial begin
    total = 0;
    bad   = 0;

    // Reset held with clocks running.
    reset = 1'b0; a = 16'h1234; b = 16'h1234; mode = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst.result", {16'h0, result}, 32'h0);
    check("rst.eq",     {31'h0, equal_flag}, 32'h0);
    check("rst.gt",     {31'h0, greater_a_flag}, 32'h0);

    // Release between edges; first capture on the next rising edge.
    reset = 1'b1;
    run_op("first", 16'h1234, 16'h1234, 3'b000, 16'h2468, 1'b1, 1'b0);

    // Arithmetic wrap.
    run_op("add_wrap", 16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1'b0, 1'b1);
    run_op("sub_wrap", 16'h0000, 16'h0001, 3'b001, 16'hFFFF, 1'b0, 1'b0);

    // Logic ops.
    run_op("and", 16'hF0F0, 16'hFF00, 3'b010, 16'hF000, 1'b0, 1'b0);
    run_op("or",  16'hF0F0, 16'hFF00, 3'b011, 16'hFFF0, 1'b0, 1'b0);
    run_op("xor", 16'hF0F0, 16'hFF00, 3'b100, 16'h0FF0, 1'b0, 1'b0);
    run_op("not", 16'hF0F0, 16'hFF00, 3'b101, 16'h0F0F, 1'b0, 1'b0);

    // Shifts and shift-amount boundaries.
    run_op("shl4",  16'h8001, 16'h0004, 3'b110, 16'h0010, 1'b0, 1'b1);
    run_op("shr15", 16'h8001, 16'h000F, 3'b111, 16'h0001, 1'b0, 1'b1);
    run_op("shl0",  16'h8001, 16'h0010, 3'b110, 16'h8001, 1'b0, 1'b1);
    run_op("shr0",  16'h8001, 16'hFFF0, 3'b111, 16'h8001, 1'b0, 1'b0);

    // Back-to-back ops covering every mode; expected {result, eq, gt}.
    pa[0] = 16'h1234; pb[0] = 16'h4321; pm[0] = 3'b000; pe[0] = {16'h5555, 1'b0, 1'b0};
    pa[1] = 16'h5000; pb[1] = 16'h0001; pm[1] = 3'b001; pe[1] = {16'h4FFF, 1'b0, 1'b1};
    pa[2] = 16'hAAAA; pb[2] = 16'h0FF0; pm[2] = 3'b010; pe[2] = {16'h0AA0, 1'b0, 1'b1};
    pa[3] = 16'h00FF; pb[3] = 16'hFF00; pm[3] = 3'b011; pe[3] = {16'hFFFF, 1'b0, 1'b0};
    pa[4] = 16'h1234; pb[4] = 16'h1234; pm[4] = 3'b100; pe[4] = {16'h0000, 1'b1, 1'b0};
    pa[5] = 16'h00FF; pb[5] = 16'h0000; pm[5] = 3'b101; pe[5] = {16'hFF00, 1'b0, 1'b1};
    pa[6] = 16'h0001; pb[6] = 16'h0003; pm[6] = 3'b110; pe[6] = {16'h0008, 1'b0, 1'b0};
    pa[7] = 16'hF000; pb[7] = 16'h000C; pm[7] = 3'b111; pe[7] = {16'h000F, 1'b0, 1'b1};

    for (int i = 0; i < 8; i++) begin
      a = pa[i]; b = pb[i]; mode = pm[i];
      exp_q.push_back(pe[i]);
      @(posedge clk); #1;
      // Outputs now show exactly the op driven before this edge.
      if (exp_q.size() != 0) begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check($sformatf("pipe%0d", i), {14'h0, result, equal_flag, greater_a_flag}, {14'h0, e});
      end
    end
    check("pipe.drained", exp_q.size(), 32'd0);

    // Async reset mid-cycle: outputs clear well before the next edge.
    a = 16'h7777; b = 16'h1111; mode = 3'b000;
    reset = 1'b0;
    #2;
    check("arst.result", {16'h0, result}, 32'h0);
    check("arst.gt",     {31'h0, greater_a_flag}, 32'h0);
    @(posedge clk); #1;
    check("arst.hold", {16'h0, result}, 32'h0);
    reset = 1'b1;
    run_op("post_rst", 16'h0003, 16'h0004, 3'b000, 16'h0007, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/x3q16_alu.md
Name: x3q16_alu

Overview:
- 16-bit, 8-operation ALU for the x3q16 datapath, with a one-cycle registered output stage.
- Takes two operands and a 3-bit opcode; produces a 16-bit result plus equal and a-greater-than-b compare flags.
- Used by the core's execute stage; flags feed the branch/compare logic.

Parameters:
- WIDTH, 16, operand/result width; all behaviour below assumes 16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- a  input  16  operand A, unsigned.
- b  input  16  operand B, unsigned.
- mode  input  3  operation select.
- result  output  16  registered operation result.
- equal_flag  output  1  registered, 1 when a == b.
- greater_a_flag  output  1  registered, 1 when a > b (unsigned).

Behaviour:
- Reset (reset = 0, asynchronous): result = 16'h0000, equal_flag = 0, greater_a_flag = 0, held while asserted.
- Reset is deasserted synchronously in effect: the first capture happens on the first rising clk edge with reset = 1.
- Latency: a, b and mode are sampled at a rising clk edge. result and both flags reflect those samples immediately after that edge and hold until the next edge. There is no handshake; a new operation is accepted every cycle.
- Reset mid-operation: outputs clear at once; the in-flight operation is discarded.
- Mode encoding (all arithmetic is modulo 2^16; carry and borrow are dropped):
  - 000 ADD: a + b
  - 001 SUB: a - b (two's-complement wrap)
  - 010 AND: a & b
  - 011 OR: a | b
  - 100 XOR: a ^ b
  - 101 NOT: ~a (b ignored)
  - 110 SHL: a << b[3:0], logical; b[15:4] ignored
  - 111 SHR: a >> b[3:0], logical, zero fill; b[15:4] ignored
- Flags are computed from a and b in every mode, independent of the operation:
  - equal_flag = (a == b)
  - greater_a_flag = (a > b), unsigned
  - The two flags are never both 1.
- Boundaries:
  - ADD 16'hFFFF + 16'h0001 = 16'h0000.
  - SUB 16'h0000 - 16'h0001 = 16'hFFFF.
  - Shift amount 0 returns a unchanged; shift amount 15 is the maximum.
- Inputs containing X/Z are not supported. Outputs are undefined for that cycle only.

Decomposition:
- Shared package x3q16_pkg holds:
  - the 3-bit mode localparams (ALU_ADD=3'b000 … ALU_SHR=3'b111)
  - the data-width constant (16)
- Natural single sub-module: x3q16_alu_core.
  - Purely combinational; computes next_result, next_eq and next_gt from a, b and mode.
  - The top wraps it with the reset-able output register.

Test Plan:
- Reset: hold reset = 0 with a = 16'h1234, b = 16'h1234, mode = 000, clocks running -> result = 0, equal_flag = 0, greater_a_flag = 0. Release reset; after the first rising edge -> result = 16'h2468, equal_flag = 1, greater_a_flag = 0.
- Arithmetic wrap:
  - ADD a = 16'hFFFF, b = 16'h0001 -> result = 16'h0000, equal_flag = 0, greater_a_flag = 1.
  - SUB a = 16'h0000, b = 16'h0001 -> result = 16'hFFFF, equal_flag = 0, greater_a_flag = 0.
- Logic ops with a = 16'hF0F0, b = 16'hFF00:
  - AND -> 16'hF000
  - OR -> 16'hFFF0
  - XOR -> 16'h0FF0
  - NOT -> 16'h0F0F
  - greater_a_flag = 0 in every case.
- Shifts with a = 16'h8001:
  - SHL b = 16'h0004 -> 16'h0010
  - SHR b = 16'h000F -> 16'h0001
  - SHL b = 16'h0010 (low nibble 0) -> 16'h8001
- Pipelining: change a/b/mode on every cycle for 8 back-to-back ops covering all modes. Each output must match the previous edge's inputs with exactly 1-cycle latency.
- Async reset mid-stream: drop reset between edges -> outputs clear before the next clk edge. Resume with the first post-reset op correct.
